// File: rtl/scoreboard_pkg.sv
// Shared definitions for the scoreboard game controller.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package scoreboard_pkg;

  localparam int SCORE_W = 7;

  // Display scheduler states.
  typedef enum logic [1:0] {
    ST_ALT  = 2'd0,
    ST_HOLD = 2'd1,
    ST_WIN  = 2'd2
  } state_e;

  // winner_o encodings; the arbiter reuses P1/P2 as its one-hot grant codes.
  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;

  // Increment that sticks at max_v.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s,
                                                 input logic [SCORE_W-1:0] max_v);
    return (s >= max_v) ? s : s + 7'd1;
  endfunction

endpackage

// File: rtl/score_arbiter.sv
// Round-robin arbiter folding both players' short presses onto one update port.
// Latency: fresh request granted combinationally; the loser of a tie is granted next cycle.
// Backpressure: none upstream; a short for a player already pending is dropped.
//
// Ports: clk_1khz_i/rst_n_i clock and async active-low reset; flush_i clears pending
// and suppresses grants; req_i {p2,p1} short presses; gnt_vld_o/gnt_o one-hot grant.
module score_arbiter
  import scoreboard_pkg::*;
(
  input  logic       clk_1khz_i,
  input  logic       rst_n_i,
  input  logic       flush_i,
  input  logic [1:0] req_i,
  output logic       gnt_vld_o,
  output logic [1:0] gnt_o
);

  logic       ptr_q, ptr_d;    // 0 = P1 wins a tie, 1 = P2 wins a tie
  logic [1:0] pend_q, pend_d;

  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_o     = 2'b00;
    ptr_d     = ptr_q;
    pend_d    = pend_q;
    if (flush_i) begin
      pend_d = 2'b00;
    end else if (pend_q != 2'b00) begin
      // Pending request goes first. A repeat from the same player is dropped;
      // a fresh request from the other player has to wait its turn.
      gnt_vld_o = 1'b1;
      gnt_o     = pend_q;
      pend_d    = req_i & ~pend_q;
    end else if (req_i == 2'b11) begin
      gnt_vld_o = 1'b1;
      gnt_o     = ptr_q ? WINNER_P2 : WINNER_P1;
      pend_d    = ptr_q ? WINNER_P1 : WINNER_P2;
      ptr_d     = ~ptr_q;
    end else if (req_i != 2'b00) begin
      gnt_vld_o = 1'b1;
      gnt_o     = req_i;
      // Point at the player that was not just served.
      ptr_d     = req_i[0];
    end
    // The pointer only moves when fresh requests are arbitrated, so servicing
    // the deferred half of a tie does not undo the alternation of tie winners.
  end

  always_ff @(posedge clk_1khz_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q  <= 1'b0;
      pend_q <= 2'b00;
    end else begin
      ptr_q  <= ptr_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/score_controller.sv
// Two-player score keeper and display scheduler (ALT / HOLD / WIN).
// Latency: a granted press is visible on scores and display one cycle later.
// Backpressure: none; simultaneous presses are serialised, repeats while pending are dropped.
//
// Ports: clk_1khz_i, rst_n_i (async active-low); p1/p2 _short_i/_long_i one-cycle
// press pulses; p1/p2_score_o scores; score_o/player_sel_o displayed score and
// owner (registered together); winner_o and blink_o win indication.
// Build option: define SCORE_CTRL_WIN_EN to build the WIN state, winner_o and blink_o.
module score_controller
  import scoreboard_pkg::*;
#(
  parameter int MAX_SCORE = 99,
  parameter int WIN_SCORE = 21,
  parameter int DWELL_MS  = 1000,
  parameter int HOLD_MS   = 2000,
  parameter int BLINK_MS  = 250
) (
  input  logic               clk_1khz_i,
  input  logic               rst_n_i,
  input  logic               p1_short_i,
  input  logic               p1_long_i,
  input  logic               p2_short_i,
  input  logic               p2_long_i,
  output logic [SCORE_W-1:0] p1_score_o,
  output logic [SCORE_W-1:0] p2_score_o,
  output logic [SCORE_W-1:0] score_o,
  output logic               player_sel_o,
  output logic [1:0]         winner_o,
  output logic               blink_o
);

  localparam int DWELL_W = $clog2(DWELL_MS);
  localparam int HOLD_W  = $clog2(HOLD_MS);

  if (MAX_SCORE > 99 || WIN_SCORE > MAX_SCORE) begin : g_bad_cfg
    $error("score_controller: MAX_SCORE must be <= 99 and WIN_SCORE <= MAX_SCORE");
  end

  state_e               state_q, state_d;
  logic [SCORE_W-1:0]   p1_q, p1_d, p2_q, p2_d, score_q, score_d;
  logic                 sel_q, sel_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic                 any_long, in_win, gnt_vld;
  logic [1:0]           gnt;

  assign any_long = p1_long_i | p2_long_i;

`ifdef SCORE_CTRL_WIN_EN
  localparam int BLINK_W = $clog2(BLINK_MS);
  logic [1:0]         winner_q, winner_d;
  logic               blink_q, blink_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  assign in_win = (state_q == ST_WIN);
`else
  assign in_win = 1'b0;
`endif

  // Long presses and the WIN state both flush the arbiter, so shorts arriving
  // then neither score nor leave a pending flag behind.
  score_arbiter u_arb (
    .clk_1khz_i (clk_1khz_i),
    .rst_n_i    (rst_n_i),
    .flush_i    (any_long | in_win),
    .req_i      ({p2_short_i, p1_short_i}),
    .gnt_vld_o  (gnt_vld),
    .gnt_o      (gnt)
  );

  always_comb begin
    state_d = state_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    sel_d   = sel_q;
    dwell_d = dwell_q;
    hold_d  = hold_q;
`ifdef SCORE_CTRL_WIN_EN
    winner_d    = winner_q;
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;
`endif
    if (any_long) begin
      state_d = ST_ALT;
      p1_d    = '0;
      p2_d    = '0;
      sel_d   = 1'b0;
      dwell_d = '0;
      hold_d  = '0;
`ifdef SCORE_CTRL_WIN_EN
      winner_d    = WINNER_NONE;
      blink_d     = 1'b0;
      blink_cnt_d = '0;
`endif
    end else if (gnt_vld) begin
      if (gnt[0]) p1_d = sat_inc(p1_q, SCORE_W'(MAX_SCORE));
      else        p2_d = sat_inc(p2_q, SCORE_W'(MAX_SCORE));
      sel_d   = gnt[1];
      state_d = ST_HOLD;
      hold_d  = '0;
`ifdef SCORE_CTRL_WIN_EN
      if ((gnt[0] ? p1_d : p2_d) == SCORE_W'(WIN_SCORE)) begin
        state_d     = ST_WIN;
        winner_d    = gnt;
        blink_d     = 1'b0;
        blink_cnt_d = '0;
      end
`endif
    end else begin
      case (state_q)
        ST_ALT: begin
          if (dwell_q == DWELL_W'(DWELL_MS - 1)) begin
            sel_d   = ~sel_q;
            dwell_d = '0;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
        ST_HOLD: begin
          if (hold_q == HOLD_W'(HOLD_MS - 1)) begin
            state_d = ST_ALT;
            dwell_d = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
`ifdef SCORE_CTRL_WIN_EN
        ST_WIN: begin
          if (blink_cnt_q == BLINK_W'(BLINK_MS - 1)) begin
            blink_d     = ~blink_q;
            blink_cnt_d = '0;
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
    // Displayed score follows the next selection so both update on one edge.
    score_d = sel_d ? p2_d : p1_d;
  end

  always_ff @(posedge clk_1khz_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_ALT;
      p1_q    <= '0;
      p2_q    <= '0;
      score_q <= '0;
      sel_q   <= 1'b0;
      dwell_q <= '0;
      hold_q  <= '0;
`ifdef SCORE_CTRL_WIN_EN
      winner_q    <= WINNER_NONE;
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      score_q <= score_d;
      sel_q   <= sel_d;
      dwell_q <= dwell_d;
      hold_q  <= hold_d;
`ifdef SCORE_CTRL_WIN_EN
      winner_q    <= winner_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
`endif
    end
  end

  assign p1_score_o   = p1_q;
  assign p2_score_o   = p2_q;
  assign score_o      = score_q;
  assign player_sel_o = sel_q;
`ifdef SCORE_CTRL_WIN_EN
  assign winner_o = winner_q;
  assign blink_o  = blink_q;
`else
  assign winner_o = WINNER_NONE;
  assign blink_o  = 1'b0;
`endif

endmodule
